// File: rtl/rob_commit_unit_pkg.sv
// Shared types for the reorder-buffer commit slice: commit kinds, ROB entry layout, FSM states.
// Width defaults come from the shared defines below; a project-wide header may predefine them.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef MAX_NUM_OF_COMMITS
`define MAX_NUM_OF_COMMITS 2
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif

package rob_commit_unit_pkg;

    typedef enum logic [1:0] {
        no_commit     = 2'd0,
        reg_commit    = 2'd1,
        store_commit  = 2'd2,
        branch_commit = 2'd3
    } commit_type_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } rob_state_t;

    typedef struct packed {
        logic                               valid;
        logic                               done;
        logic                               mispredict;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] phy_wr_reg;
        logic [`ARCH_REG_NUM_WIDTH-1:0]     arch_wr_reg;
        commit_type_t                       commit_type;
    } rob_entry_t;

    // Width of a lane index; kept at least 1 bit so a single-lane build still elaborates.
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/rob_commit_unit_retire_select.sv
// Picks which of the head-relative lanes retire this cycle: an in-order run of valid&done
// entries starting at the head, cut right after the first mispredicted one.
module rob_retire_select
    import rob_commit_unit_pkg::*;
#(
    parameter int MAX_NUM_OF_COMMITS = `MAX_NUM_OF_COMMITS,
    parameter int COUNT_W            = $clog2(MAX_NUM_OF_COMMITS + 1),
    parameter int LANE_W             = lane_idx_width(MAX_NUM_OF_COMMITS)
) (
    input  logic [MAX_NUM_OF_COMMITS-1:0] lane_valid,
    input  logic [MAX_NUM_OF_COMMITS-1:0] lane_done,
    input  logic [MAX_NUM_OF_COMMITS-1:0] lane_mispredict,
    output logic [MAX_NUM_OF_COMMITS-1:0] retire_mask,
    output logic [COUNT_W-1:0]            retire_count,
    output logic                          mispredict_hit,
    output logic [LANE_W-1:0]             mispredict_lane
);

    // chain[i] is high while every lane before i retired and none of them was a mispredict.
    logic [MAX_NUM_OF_COMMITS:0] chain;

    assign chain[0] = 1'b1;

    for (genvar gi = 0; gi < MAX_NUM_OF_COMMITS; gi++) begin : g_lane
        assign retire_mask[gi] = chain[gi] & lane_valid[gi] & lane_done[gi];
        assign chain[gi+1]     = retire_mask[gi] & ~lane_mispredict[gi];
    end

    always_comb begin
        retire_count    = '0;
        mispredict_hit  = 1'b0;
        mispredict_lane = '0;
        for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
            retire_count = retire_count + COUNT_W'(retire_mask[i]);
            if (retire_mask[i] && lane_mispredict[i]) begin
                mispredict_hit  = 1'b1;
                mispredict_lane = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder-buffer commit unit: tag-indexed entry storage, in-order multi-lane retirement and
// a one-cycle flush on a retired mispredicted branch.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH         = `ROB_SIZE_WIDTH,
    parameter int MAX_NUM_OF_COMMITS     = `MAX_NUM_OF_COMMITS,
    parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
    parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              disp_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]         disp_tag,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] disp_phy_wr_reg,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]     disp_arch_wr_reg,
    input  commit_type_t                      disp_commit_type,
    input  logic                              cmpl_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]         cmpl_tag,
    input  logic                              cmpl_mispredict,
    output logic [MAX_NUM_OF_COMMITS-1:0]     commit_valid,
    output commit_type_t                      commit_type            [MAX_NUM_OF_COMMITS],
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register   [MAX_NUM_OF_COMMITS],
    output logic [ARCH_REG_NUM_WIDTH-1:0]     commited_arch_register [MAX_NUM_OF_COMMITS],
    output logic [ROB_SIZE_WIDTH-1:0]         commit_tag             [MAX_NUM_OF_COMMITS],
    output logic                              flush,
    output logic [ROB_SIZE_WIDTH-1:0]         flush_next_tag,
    output logic                              dispatch_err
);

    localparam int ROB_ENTRIES = 2 ** ROB_SIZE_WIDTH;
    localparam int COUNT_W     = $clog2(MAX_NUM_OF_COMMITS + 1);
    localparam int LANE_W      = lane_idx_width(MAX_NUM_OF_COMMITS);

    rob_state_t                      state_reg, state_next;
    rob_entry_t                      rob_mem [ROB_ENTRIES];
    logic [ROB_SIZE_WIDTH-1:0]       head_reg;
    logic [ROB_SIZE_WIDTH-1:0]       lane_idx [MAX_NUM_OF_COMMITS];
    logic [MAX_NUM_OF_COMMITS-1:0]   lane_valid, lane_done, lane_mispredict, retire_mask;
    logic [COUNT_W-1:0]              retire_count;
    logic                            mispredict_hit;
    logic [LANE_W-1:0]               mispredict_lane;
    logic [ROB_ENTRIES-1:0]          retire_hit;
    logic                            in_normal, flush_now;
    logic [ROB_SIZE_WIDTH-1:0]       flush_tag;
    logic                            disp_conflict, disp_accept, cmpl_accept;

    // Lane i looks at entry head+i; the index wraps naturally at the tag width.
    for (genvar gi = 0; gi < MAX_NUM_OF_COMMITS; gi++) begin : g_lane_read
        assign lane_idx[gi]        = head_reg + ROB_SIZE_WIDTH'(gi);
        assign lane_valid[gi]      = rob_mem[lane_idx[gi]].valid;
        assign lane_done[gi]       = rob_mem[lane_idx[gi]].done;
        assign lane_mispredict[gi] = rob_mem[lane_idx[gi]].mispredict;
    end

    rob_retire_select #(
        .MAX_NUM_OF_COMMITS (MAX_NUM_OF_COMMITS),
        .COUNT_W            (COUNT_W),
        .LANE_W             (LANE_W)
    ) u_retire_select (
        .lane_valid      (lane_valid),
        .lane_done       (lane_done),
        .lane_mispredict (lane_mispredict),
        .retire_mask     (retire_mask),
        .retire_count    (retire_count),
        .mispredict_hit  (mispredict_hit),
        .mispredict_lane (mispredict_lane)
    );

    always_comb begin
        retire_hit = '0;
        for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
            if (retire_mask[i]) begin
                retire_hit[lane_idx[i]] = 1'b1;
            end
        end
    end

    assign in_normal     = (state_reg == NORMAL);
    assign flush_now     = in_normal && mispredict_hit;
    assign flush_tag     = head_reg + ROB_SIZE_WIDTH'(mispredict_lane) + ROB_SIZE_WIDTH'(1);
    // Re-using an entry that retires in this same cycle is legal; only a live entry conflicts.
    assign disp_conflict = in_normal && disp_valid && rob_mem[disp_tag].valid && !retire_hit[disp_tag];
    assign disp_accept   = in_normal && disp_valid && !disp_conflict;
    assign cmpl_accept   = in_normal && cmpl_valid && rob_mem[cmpl_tag].valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL:  if (mispredict_hit) state_next = FLUSH;
            FLUSH:   state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Later assignments win: completion, then retirement clear, then dispatch overwrite.
    always_ff @(posedge clk) begin
        if (reset || flush_now) begin
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                rob_mem[e] <= '0;
            end
        end else if (in_normal) begin
            if (cmpl_accept) begin
                rob_mem[cmpl_tag].done       <= 1'b1;
                rob_mem[cmpl_tag].mispredict <= cmpl_mispredict;
            end
            for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
                if (retire_mask[i]) begin
                    rob_mem[lane_idx[i]].valid <= 1'b0;
                end
            end
            if (disp_accept) begin
                rob_mem[disp_tag].valid       <= 1'b1;
                rob_mem[disp_tag].done        <= 1'b0;
                rob_mem[disp_tag].mispredict  <= 1'b0;
                rob_mem[disp_tag].phy_wr_reg  <= disp_phy_wr_reg;
                rob_mem[disp_tag].arch_wr_reg <= disp_arch_wr_reg;
                rob_mem[disp_tag].commit_type <= disp_commit_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg       <= '0;
            flush          <= 1'b0;
            flush_next_tag <= '0;
            dispatch_err   <= 1'b0;
        end else begin
            flush <= flush_now;
            if (flush_now) begin
                head_reg       <= flush_tag;
                flush_next_tag <= flush_tag;
            end else if (in_normal) begin
                head_reg <= head_reg + ROB_SIZE_WIDTH'(retire_count);
            end
            if (disp_conflict) begin
                dispatch_err <= 1'b1;
            end
        end
    end

    // The mispredicted branch still commits: the flush edge is taken from NORMAL.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
            if (!reset && in_normal && retire_mask[i]) begin
                commit_valid[i]           <= 1'b1;
                commit_type[i]            <= rob_mem[lane_idx[i]].commit_type;
                commited_wr_register[i]   <= rob_mem[lane_idx[i]].phy_wr_reg;
                commited_arch_register[i] <= rob_mem[lane_idx[i]].arch_wr_reg;
                commit_tag[i]             <= lane_idx[i];
            end else begin
                commit_valid[i]           <= 1'b0;
                commit_type[i]            <= no_commit;
                commited_wr_register[i]   <= '0;
                commited_arch_register[i] <= '0;
                commit_tag[i]             <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit (4-bit tags, 2 commit lanes, phy 6 bits, arch 5 bits).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic         clk;
    logic         reset;
    logic         disp_valid;
    logic [3:0]   disp_tag;
    logic [5:0]   disp_phy_wr_reg;
    logic [4:0]   disp_arch_wr_reg;
    commit_type_t disp_commit_type;
    logic         cmpl_valid;
    logic [3:0]   cmpl_tag;
    logic         cmpl_mispredict;
    logic [1:0]   commit_valid;
    commit_type_t commit_type            [2];
    logic [5:0]   commited_wr_register   [2];
    logic [4:0]   commited_arch_register [2];
    logic [3:0]   commit_tag             [2];
    logic         flush;
    logic [3:0]   flush_next_tag;
    logic         dispatch_err;

    int errors = 0;
    int checks = 0;

    rob_commit_unit #(
        .ROB_SIZE_WIDTH         (4),
        .MAX_NUM_OF_COMMITS     (2),
        .PHYSICAL_REG_NUM_WIDTH (6),
        .ARCH_REG_NUM_WIDTH     (5)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .disp_valid             (disp_valid),
        .disp_tag               (disp_tag),
        .disp_phy_wr_reg        (disp_phy_wr_reg),
        .disp_arch_wr_reg       (disp_arch_wr_reg),
        .disp_commit_type       (disp_commit_type),
        .cmpl_valid             (cmpl_valid),
        .cmpl_tag               (cmpl_tag),
        .cmpl_mispredict        (cmpl_mispredict),
        .commit_valid           (commit_valid),
        .commit_type            (commit_type),
        .commited_wr_register   (commited_wr_register),
        .commited_arch_register (commited_arch_register),
        .commit_tag             (commit_tag),
        .flush                  (flush),
        .flush_next_tag         (flush_next_tag),
        .dispatch_err           (dispatch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        $display("reset applied");
    endtask

    task automatic dispatch(input logic [3:0] tag, input logic [5:0] phy, input logic [4:0] arch,
                            input commit_type_t ctype);
        disp_valid       = 1'b1;
        disp_tag         = tag;
        disp_phy_wr_reg  = phy;
        disp_arch_wr_reg = arch;
        disp_commit_type = ctype;
        tick();
        disp_valid = 1'b0;
        $display("dispatch tag=%0d phy=%0d arch=%0d type=%0d", tag, phy, arch, ctype);
    endtask

    task automatic complete(input logic [3:0] tag, input logic mis);
        cmpl_valid      = 1'b1;
        cmpl_tag        = tag;
        cmpl_mispredict = mis;
        tick();
        cmpl_valid      = 1'b0;
        cmpl_mispredict = 1'b0;
        $display("complete tag=%0d mispredict=%0d commit_valid=%b", tag, mis, commit_valid);
    endtask

    initial begin
        reset            = 1'b1;
        disp_valid       = 1'b0;
        disp_tag         = '0;
        disp_phy_wr_reg  = '0;
        disp_arch_wr_reg = '0;
        disp_commit_type = no_commit;
        cmpl_valid       = 1'b0;
        cmpl_tag         = '0;
        cmpl_mispredict  = 1'b0;

        // Reset state
        do_reset();
        check("rst_commit_valid", 32'(commit_valid), 32'h0);
        check("rst_commit_type0", 32'(commit_type[0]), 32'(no_commit));
        check("rst_commit_tag1", 32'(commit_tag[1]), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_flush_next_tag", 32'(flush_next_tag), 32'h0);
        check("rst_dispatch_err", 32'(dispatch_err), 32'h0);

        // Out-of-order completion, in-order commit
        dispatch(4'd0, 6'd5, 5'd1, reg_commit);
        dispatch(4'd1, 6'd6, 5'd2, reg_commit);
        dispatch(4'd2, 6'd7, 5'd3, reg_commit);
        complete(4'd2, 1'b0);
        check("ooo_after_c2", 32'(commit_valid), 32'h0);
        complete(4'd1, 1'b0);
        check("ooo_after_c1", 32'(commit_valid), 32'h0);
        complete(4'd0, 1'b0);
        check("ooo_latency", 32'(commit_valid), 32'h0);
        tick();
        $display("commit cycle A valid=%b", commit_valid);
        check("ooo_pair_valid", 32'(commit_valid), 32'h3);
        check("ooo_pair_tag0", 32'(commit_tag[0]), 32'd0);
        check("ooo_pair_tag1", 32'(commit_tag[1]), 32'd1);
        check("ooo_pair_phy0", 32'(commited_wr_register[0]), 32'd5);
        check("ooo_pair_phy1", 32'(commited_wr_register[1]), 32'd6);
        check("ooo_pair_arch1", 32'(commited_arch_register[1]), 32'd2);
        check("ooo_pair_type0", 32'(commit_type[0]), 32'(reg_commit));
        tick();
        $display("commit cycle B valid=%b", commit_valid);
        check("ooo_last_valid", 32'(commit_valid), 32'h1);
        check("ooo_last_tag", 32'(commit_tag[0]), 32'd2);
        check("ooo_last_phy", 32'(commited_wr_register[0]), 32'd7);
        check("ooo_unused_type", 32'(commit_type[1]), 32'(no_commit));
        tick();
        check("ooo_drained", 32'(commit_valid), 32'h0);

        // Mispredicted branch: commits itself, flushes the younger entry
        do_reset();
        dispatch(4'd0, 6'd8, 5'd4, branch_commit);
        dispatch(4'd1, 6'd9, 5'd5, reg_commit);
        complete(4'd0, 1'b1);
        check("mis_latency", 32'(commit_valid), 32'h0);
        complete(4'd1, 1'b0);
        check("mis_valid", 32'(commit_valid), 32'h1);
        check("mis_tag", 32'(commit_tag[0]), 32'd0);
        check("mis_type", 32'(commit_type[0]), 32'(branch_commit));
        check("mis_flush", 32'(flush), 32'h1);
        check("mis_next_tag", 32'(flush_next_tag), 32'd1);
        tick();
        check("mis_flush_cycle_valid", 32'(commit_valid), 32'h0);
        check("mis_flush_pulse", 32'(flush), 32'h0);
        tick();
        check("mis_tag1_gone", 32'(commit_valid), 32'h0);
        dispatch(4'd1, 6'd10, 5'd6, reg_commit);
        complete(4'd1, 1'b0);
        tick();
        check("mis_resume_valid", 32'(commit_valid), 32'h1);
        check("mis_resume_tag", 32'(commit_tag[0]), 32'd1);
        check("mis_resume_phy", 32'(commited_wr_register[0]), 32'd10);
        check("mis_no_err", 32'(dispatch_err), 32'h0);

        // Head wrap: bring head to 15, then commit 15 and 0 together
        do_reset();
        for (int t = 0; t < 15; t++) dispatch(4'(t), 6'(t), 5'(t), reg_commit);
        for (int t = 0; t < 15; t++) complete(4'(t), 1'b0);
        tick();
        tick();
        check("wrap_idle", 32'(commit_valid), 32'h0);
        dispatch(4'd15, 6'd20, 5'd7, reg_commit);
        dispatch(4'd0, 6'd21, 5'd8, store_commit);
        complete(4'd0, 1'b0);
        check("wrap_not_head", 32'(commit_valid), 32'h0);
        complete(4'd15, 1'b0);
        check("wrap_latency", 32'(commit_valid), 32'h0);
        tick();
        check("wrap_valid", 32'(commit_valid), 32'h3);
        check("wrap_tag0", 32'(commit_tag[0]), 32'd15);
        check("wrap_tag1", 32'(commit_tag[1]), 32'd0);
        check("wrap_type1", 32'(commit_type[1]), 32'(store_commit));
        check("wrap_phy0", 32'(commited_wr_register[0]), 32'd20);
        dispatch(4'd1, 6'd22, 5'd9, reg_commit);
        complete(4'd1, 1'b0);
        tick();
        check("wrap_head1_valid", 32'(commit_valid), 32'h1);
        check("wrap_head1_tag", 32'(commit_tag[0]), 32'd1);

        // Dispatch into a retiring entry is fine; into a live one is sticky error
        do_reset();
        dispatch(4'd0, 6'd1, 5'd1, reg_commit);
        complete(4'd0, 1'b0);
        dispatch(4'd0, 6'd2, 5'd2, reg_commit);
        check("reuse_commit_valid", 32'(commit_valid), 32'h1);
        check("reuse_commit_phy", 32'(commited_wr_register[0]), 32'd1);
        check("reuse_no_err", 32'(dispatch_err), 32'h0);
        dispatch(4'd3, 6'd3, 5'd3, reg_commit);
        check("dup_first_ok", 32'(dispatch_err), 32'h0);
        dispatch(4'd3, 6'd4, 5'd4, reg_commit);
        check("dup_err_set", 32'(dispatch_err), 32'h1);
        tick();
        check("dup_err_sticky", 32'(dispatch_err), 32'h1);
        do_reset();
        check("dup_err_cleared", 32'(dispatch_err), 32'h0);

        // Reset mid-operation discards in-flight entries
        for (int t = 0; t < 4; t++) dispatch(4'(t), 6'(t + 30), 5'(t), reg_commit);
        complete(4'd0, 1'b0);
        check("midrst_latency", 32'(commit_valid), 32'h0);
        reset = 1'b1;
        complete(4'd1, 1'b0);
        reset = 1'b0;
        check("midrst_no_commit", 32'(commit_valid), 32'h0);
        complete(4'd2, 1'b0);
        check("midrst_old2", 32'(commit_valid), 32'h0);
        complete(4'd3, 1'b0);
        check("midrst_old3", 32'(commit_valid), 32'h0);
        complete(4'd0, 1'b0);
        check("midrst_old0", 32'(commit_valid), 32'h0);
        tick();
        check("midrst_idle", 32'(commit_valid), 32'h0);
        check("midrst_no_flush", 32'(flush), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
